// File: rtl/tick_pkg.sv
// Shared types and constants for the tick scheduler slice.
//   sw_state_e  : stopwatch FSM states (idle / run / hold)
//   tmr_state_e : countdown FSM states, encoded as seen on tmr_state_o
//   TMR_W       : width of the countdown value in seconds
package tick_pkg;

  localparam int unsigned TMR_W = 12;

  typedef enum logic [1:0] {
    SwIdle = 2'd0,
    SwRun  = 2'd1,
    SwHold = 2'd2
  } sw_state_e;

  typedef enum logic [1:0] {
    TmrIdle   = 2'd0,
    TmrLoaded = 2'd1,
    TmrRun    = 2'd2,
    TmrDone   = 2'd3
  } tmr_state_e;

  // Counter width needed to hold 0..div-1 (at least one bit).
  function automatic int unsigned cnt_width(int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Phase counter producing a one-cycle tick enable every DIV enabled cycles.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset, counter to 0
//   clr_i   : synchronous clear of the phase counter (beats en_i)
//   en_i    : advance the phase counter this cycle
//   tick_o  : high while enabled and the counter sits at DIV-1
module tick_prescaler
  import tick_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by en_i so a frozen counter parked at DIV-1 does not keep ticking.
  assign tick_o = en_i && (cnt_q == Last);

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler: time-of-day tick, stopwatch tick with run/hold/clear and a
// seconds countdown timer. All ticks are clock enables on clk.
// Optional feature macro: TICK_TENTHS_EN adds tick_10hz_o and makes the
// stopwatch tick at ten times the base rate.
// Ports:
//   clk, reset                 : clock and asynchronous active-low reset
//   sw_start_i/stop_i/clear_i  : stopwatch command pulses
//   tmr_load_i/start_i/pause_i : countdown command pulses
//   tmr_value_i                : countdown load value (seconds)
//   tick_tod_o                 : base-rate tick enable
//   tick_sw_o, tick_tmr_o      : stopwatch / countdown tick enables
//   sw_running_o               : stopwatch in run
//   tmr_state_o                : countdown state (IDLE=0 LOADED=1 RUN=2 DONE=3)
//   tmr_remaining_o            : seconds left
//   tmr_expired_o              : one-cycle pulse after reaching zero
//   tick_10hz_o                : tenths tick (TICK_TENTHS_EN only)
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_start_i,
  input  logic             sw_stop_i,
  input  logic             sw_clear_i,
  input  logic             tmr_load_i,
  input  logic             tmr_start_i,
  input  logic             tmr_pause_i,
  input  logic [TMR_W-1:0] tmr_value_i,
  output logic             tick_tod_o,
  output logic             tick_sw_o,
  output logic             tick_tmr_o,
  output logic             sw_running_o,
  output logic [1:0]       tmr_state_o,
  output logic [TMR_W-1:0] tmr_remaining_o,
`ifdef TICK_TENTHS_EN
  output logic             tick_10hz_o,
`endif
  output logic             tmr_expired_o
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
`ifdef TICK_TENTHS_EN
  localparam int unsigned SwDiv = DIV / 10;
`else
  localparam int unsigned SwDiv = DIV;
`endif

  sw_state_e        sw_state_q;
  logic             sw_running_q;
  tmr_state_e       tmr_state_q;
  logic [TMR_W-1:0] tmr_rem_q;
  logic             tmr_expired_q;

  logic sw_clr;
  logic tmr_tick;
  logic load_ok;

  // Time-of-day base tick, free running.
  tick_prescaler #(
    .DIV (DIV)
  ) u_tod (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (1'b0),
    .en_i   (1'b1),
    .tick_o (tick_tod_o)
  );

`ifdef TICK_TENTHS_EN
  tick_prescaler #(
    .DIV (DIV / 10)
  ) u_tenths (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (1'b0),
    .en_i   (1'b1),
    .tick_o (tick_10hz_o)
  );
`endif

  // Stopwatch phase: cleared on any clear and on a fresh start from idle,
  // frozen in hold so a resume keeps the partial period.
  assign sw_clr = sw_clear_i || ((sw_state_q == SwIdle) && sw_start_i);

  tick_prescaler #(
    .DIV (SwDiv)
  ) u_sw (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (sw_clr),
    .en_i   (sw_state_q == SwRun),
    .tick_o (tick_sw_o)
  );

  // Stopwatch FSM; clear beats start/stop, start+stop toggles run/hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_state_q   <= SwIdle;
      sw_running_q <= 1'b0;
    end else if (sw_clear_i) begin
      sw_state_q   <= SwIdle;
      sw_running_q <= 1'b0;
    end else begin
      case (sw_state_q)
        SwIdle: begin
          if (sw_start_i) begin
            sw_state_q   <= SwRun;
            sw_running_q <= 1'b1;
          end
        end
        SwRun: begin
          if (sw_stop_i) begin
            sw_state_q   <= SwHold;
            sw_running_q <= 1'b0;
          end
        end
        SwHold: begin
          if (sw_start_i) begin
            sw_state_q   <= SwRun;
            sw_running_q <= 1'b1;
          end
        end
        default: begin
          sw_state_q   <= SwIdle;
          sw_running_q <= 1'b0;
        end
      endcase
    end
  end

  assign tmr_tick = tick_tod_o && (tmr_state_q == TmrRun);
  assign load_ok  = tmr_load_i && (tmr_value_i != '0);

  // Countdown FSM. A tick that reaches zero wins over a same-cycle pause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_state_q   <= TmrIdle;
      tmr_rem_q     <= '0;
      tmr_expired_q <= 1'b0;
    end else begin
      tmr_expired_q <= 1'b0;
      unique case (tmr_state_q)
        TmrIdle, TmrDone: begin
          if (load_ok) begin
            tmr_rem_q   <= tmr_value_i;
            tmr_state_q <= TmrLoaded;
          end
        end
        TmrLoaded: begin
          if (load_ok) begin
            tmr_rem_q <= tmr_value_i;
          end else if (tmr_start_i && !tmr_pause_i) begin
            tmr_state_q <= TmrRun;
          end
        end
        TmrRun: begin
          if (tmr_tick && (tmr_rem_q != '0)) begin
            tmr_rem_q <= tmr_rem_q - 1'b1;
            if (tmr_rem_q == TMR_W'(1)) begin
              tmr_state_q   <= TmrDone;
              tmr_expired_q <= 1'b1;
            end else if (tmr_pause_i) begin
              tmr_state_q <= TmrLoaded;
            end
          end else if (tmr_pause_i) begin
            tmr_state_q <= TmrLoaded;
          end
        end
      endcase
    end
  end

  assign tick_tmr_o      = tmr_tick;
  assign sw_running_o    = sw_running_q;
  assign tmr_state_o     = tmr_state_q;
  assign tmr_remaining_o = tmr_rem_q;
  assign tmr_expired_o   = tmr_expired_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler with CLK_HZ=20, TICK_HZ=1 (DIV=20).
// Edge numbering: edge 1 is the first rising clk edge after reset release.
// A tick "at edge N" is high in the cycle sampled by edge N, i.e. visible
// just after edge N-1.
module tb_tick_scheduler;

  localparam int unsigned CLK_HZ  = 20;
  localparam int unsigned TICK_HZ = 1;
  localparam int          DIV     = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sw_start = 1'b0, sw_stop = 1'b0, sw_clear = 1'b0;
  logic        tmr_load = 1'b0, tmr_start = 1'b0, tmr_pause = 1'b0;
  logic [11:0] tmr_value = '0;
  logic        tick_tod, tick_sw, tick_tmr, sw_running, tmr_expired;
  logic [1:0]  tmr_state;
  logic [11:0] tmr_remaining;

  int checks = 0;
  int errors = 0;

  tick_scheduler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .sw_start_i      (sw_start),
    .sw_stop_i       (sw_stop),
    .sw_clear_i      (sw_clear),
    .tmr_load_i      (tmr_load),
    .tmr_start_i     (tmr_start),
    .tmr_pause_i     (tmr_pause),
    .tmr_value_i     (tmr_value),
    .tick_tod_o      (tick_tod),
    .tick_sw_o       (tick_sw),
    .tick_tmr_o      (tick_tmr),
    .sw_running_o    (sw_running),
    .tmr_state_o     (tmr_state),
    .tmr_remaining_o (tmr_remaining),
    .tmr_expired_o   (tmr_expired)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset, time spent running, plus timer rules.
  int m_cycle;    // edges since reset release
  int m_sw;       // 0 idle, 1 run, 2 hold
  int m_sw_el;    // cycles spent running since last clear/fresh start
  int m_tst;      // 0 idle, 1 loaded, 2 run, 3 done
  int m_rem;
  bit m_exp;

  function automatic bit m_tod();
    return (m_cycle % DIV) == DIV - 1;
  endfunction

  function automatic logic [18:0] m_out();
    bit tod;
    bit sw;
    tod = m_tod();
    sw  = (m_sw == 1) && ((m_sw_el % DIV) == DIV - 1);
    return {tod, sw, tod && (m_tst == 2), m_sw == 1, 2'(m_tst), 12'(m_rem), m_exp};
  endfunction

  function automatic logic [18:0] dut_out();
    return {tick_tod, tick_sw, tick_tmr, sw_running, tmr_state, tmr_remaining, tmr_expired};
  endfunction

  task automatic model_edge();
    bit tick;
    bit ld;
    tick = m_tod() && (m_tst == 2);
    ld   = tmr_load && (tmr_value != 0);
    if (m_sw == 1) m_sw_el++;
    if (sw_clear) begin
      m_sw = 0;
      m_sw_el = 0;
    end else if (m_sw == 0 && sw_start) begin
      m_sw = 1;
      m_sw_el = 0;
    end else if (m_sw == 1 && sw_stop) begin
      m_sw = 2;
    end else if (m_sw == 2 && sw_start) begin
      m_sw = 1;
    end
    m_exp = 1'b0;
    case (m_tst)
      0, 3: if (ld) begin m_rem = int'(tmr_value); m_tst = 1; end
      1: begin
        if (ld) m_rem = int'(tmr_value);
        else if (tmr_start && !tmr_pause) m_tst = 2;
      end
      default: begin
        if (tick) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_tst = 3; m_exp = 1'b1; end
          else if (tmr_pause) m_tst = 1;
        end else if (tmr_pause) begin
          m_tst = 1;
        end
      end
    endcase
    m_cycle++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sw_start = 0; sw_stop = 0; sw_clear = 0;
    tmr_load = 0; tmr_start = 0; tmr_pause = 0; tmr_value = '0;
  endtask

  // Asserts reset at the current time, checks outputs before any clk edge.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (dut_out() !== 19'd0) begin
      errors++;
      $display("FAIL %s_async_zero: got %h expected 0", tag, dut_out());
    end
    m_cycle = 0; m_sw = 0; m_sw_el = 0; m_tst = 0; m_rem = 0; m_exp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_tod();
    apply_reset("tod");
    for (int e = 1; e <= 60; e++) begin
      bit exp_t;
      step();
      exp_t = (e == 19) || (e == 39) || (e == 59);
      checks++;
      if (tick_tod !== exp_t) begin
        errors++;
        $display("FAIL tod_tick at edge %0d: got %b expected %b", e + 1, tick_tod, exp_t);
      end
    end
  endtask

  task automatic test_stopwatch();
    apply_reset("sw");
    for (int e = 1; e <= 60; e++) begin
      bit exp_t;
      sw_start = (e == 5) || (e == 45);
      sw_stop  = (e == 35);
      step();
      clear_inputs();
      exp_t = (e == 24) || (e == 54);
      checks++;
      if (tick_sw !== exp_t) begin
        errors++;
        $display("FAIL sw_tick at edge %0d: got %b expected %b", e + 1, tick_sw, exp_t);
      end
      if (e == 10 || e == 40 || e == 50) begin
        checks++;
        if (sw_running !== (e != 40)) begin
          errors++;
          $display("FAIL sw_running after edge %0d: got %b expected %b", e, sw_running, e != 40);
        end
      end
    end
  endtask

  task automatic test_countdown();
    int n_exp = 0;
    apply_reset("cd");
    for (int e = 1; e <= 80; e++) begin
      tmr_load  = (e == 2);
      tmr_value = 12'd3;
      tmr_start = (e == 3) || (e == 70);
      step();
      clear_inputs();
      if (tmr_expired === 1'b1) n_exp++;
      if (e == 2) begin
        checks++;
        if ({tmr_state, tmr_remaining} !== {2'd1, 12'd3}) begin
          errors++;
          $display("FAIL cd_load: got %0d/%0d expected 1/3", tmr_state, tmr_remaining);
        end
      end
      if (e == 19) begin
        checks++;
        if (tick_tmr !== 1'b1) begin
          errors++;
          $display("FAIL cd_tick_tmr: got %b expected 1", tick_tmr);
        end
      end
      if (e == 20 || e == 40) begin
        checks++;
        if ({tmr_state, tmr_remaining} !== {2'd2, 12'(e == 20 ? 2 : 1)}) begin
          errors++;
          $display("FAIL cd_dec edge %0d: got %0d/%0d expected 2/%0d", e, tmr_state,
                   tmr_remaining, e == 20 ? 2 : 1);
        end
      end
      if (e == 60) begin
        checks++;
        if ({tmr_state, tmr_remaining, tmr_expired} !== {2'd3, 12'd0, 1'b1}) begin
          errors++;
          $display("FAIL cd_done: got %0d/%0d/%b expected 3/0/1", tmr_state, tmr_remaining,
                   tmr_expired);
        end
      end
      if (e == 61 || e == 75) begin
        checks++;
        if ({tmr_state, tmr_expired} !== {2'd3, 1'b0}) begin
          errors++;
          $display("FAIL cd_after_done edge %0d: got %0d/%b expected 3/0", e, tmr_state,
                   tmr_expired);
        end
      end
    end
    checks++;
    if (n_exp != 1) begin
      errors++;
      $display("FAIL cd_expired_count: got %0d expected 1", n_exp);
    end
  endtask

  task automatic test_pause_and_ignored_loads();
    apply_reset("pause");
    for (int e = 1; e <= 60; e++) begin
      tmr_load  = (e == 2) || (e == 5) || (e == 27);
      tmr_value = (e == 2) ? 12'd5 : (e == 5) ? 12'd9 : 12'd0;
      tmr_start = (e == 3);
      tmr_pause = (e == 25);
      step();
      clear_inputs();
      if (e == 5 || e == 20 || e == 25 || e == 27 || e == 60) begin
        logic [1:0]  es;
        logic [11:0] er;
        es = (e < 25) ? 2'd2 : 2'd1;
        er = (e < 20) ? 12'd5 : 12'd4;
        checks++;
        if ({tmr_state, tmr_remaining} !== {es, er}) begin
          errors++;
          $display("FAIL pause edge %0d: got %0d/%0d expected %0d/%0d", e, tmr_state,
                   tmr_remaining, es, er);
        end
      end
      if (e == 59) begin
        checks++;
        if (tick_tmr !== 1'b0) begin
          errors++;
          $display("FAIL pause_no_tick_tmr: got %b expected 0", tick_tmr);
        end
      end
    end
  endtask

  task automatic test_sw_clear_priority();
    apply_reset("swclr");
    for (int e = 1; e <= 30; e++) begin
      sw_start = (e == 2) || (e == 8);
      sw_clear = (e == 8);
      step();
      clear_inputs();
      if (e == 5 || e == 8 || e == 30) begin
        checks++;
        if (sw_running !== (e == 5)) begin
          errors++;
          $display("FAIL swclr_running edge %0d: got %b expected %b", e, sw_running, e == 5);
        end
      end
      if (e == 21) begin
        checks++;
        if (tick_sw !== 1'b0) begin
          errors++;
          $display("FAIL swclr_no_tick: got %b expected 0", tick_sw);
        end
      end
    end
  endtask

  task automatic test_reset_mid_countdown();
    int n_exp = 0;
    apply_reset("mid");
    for (int e = 1; e <= 25; e++) begin
      tmr_load  = (e == 2);
      tmr_value = 12'd3;
      tmr_start = (e == 3);
      step();
      clear_inputs();
    end
    checks++;
    if (tmr_remaining !== 12'd2) begin
      errors++;
      $display("FAIL mid_remaining: got %0d expected 2", tmr_remaining);
    end
    apply_reset("mid_reset");
    for (int e = 1; e <= 80; e++) begin
      step();
      if (tmr_expired === 1'b1) n_exp++;
    end
    checks++;
    if ({n_exp != 0, tmr_state, tmr_remaining} !== 15'd0) begin
      errors++;
      $display("FAIL mid_after_release: expired %0d state %0d rem %0d expected 0/0/0", n_exp,
               tmr_state, tmr_remaining);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    apply_reset("rand");
    for (int i = 0; i < 4000; i++) begin
      sw_start  = $urandom_range(0, 99) < 3;
      sw_stop   = $urandom_range(0, 99) < 3;
      sw_clear  = $urandom_range(0, 99) < 1;
      tmr_load  = $urandom_range(0, 99) < 4;
      tmr_start = $urandom_range(0, 99) < 8;
      tmr_pause = $urandom_range(0, 99) < 2;
      tmr_value = 12'($urandom_range(0, 4));
      step();
      checks++;
      if (dut_out() !== m_out()) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random cycle %0d: got %h expected %h", i, dut_out(), m_out());
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_tod();
    test_stopwatch();
    test_countdown();
    test_pause_and_ignored_loads();
    test_sw_clear_priority();
    test_reset_mid_countdown();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, base tick rate. DIV = CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 clk  in  1  system clock; all state is updated on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 sw_start, sw_stop, sw_clear  in  1 each  stopwatch commands, single-cycle pulses.
REQ-006 tmr_load, tmr_start, tmr_pause  in  1 each  countdown commands, single-cycle pulses.
REQ-007 tmr_value  in  12  countdown load value in seconds.
REQ-008 tick_tod  out  1  one-cycle time-of-day tick enable.
REQ-009 tick_sw, tick_tmr  out  1 each  one-cycle stopwatch and countdown tick enables.
REQ-010 sw_running  out  1  high while the stopwatch is in RUN.
REQ-011 tmr_state  out  2  encoding IDLE=0, LOADED=1, RUN=2, DONE=3.
REQ-012 tmr_remaining  out  12  seconds left; tmr_expired  out  1  one-cycle pulse.

Function
REQ-013 All tick outputs SHALL be clock enables; no derived clocks are generated.
REQ-014 The TOD phase counter SHALL count 0..DIV-1 and wrap to 0; tick_tod is high for one cycle when the counter equals DIV-1.
REQ-015 Stopwatch FSM: IDLE -> RUN on sw_start; RUN -> HOLD on sw_stop; HOLD -> RUN on sw_start; any state -> IDLE on sw_clear.
REQ-016 sw_clear SHALL beat sw_start/sw_stop in the same cycle; sw_start together with sw_stop in RUN gives HOLD; in HOLD it gives RUN.
REQ-017 The stopwatch SHALL own a phase counter (0..DIV-1) that is cleared on entering IDLE and on IDLE->RUN, frozen in HOLD, and advanced in RUN.
REQ-018 tick_sw SHALL pulse when the stopwatch phase counter equals DIV-1 in RUN, so the first tick comes exactly DIV cycles after sw_start from IDLE and a resume keeps the partial second.
REQ-019 tmr_load with tmr_value != 0 in IDLE, LOADED or DONE SHALL set tmr_remaining = tmr_value next cycle and enter LOADED.
REQ-020 tmr_load is ignored in RUN; tmr_load with value 0 is ignored in every state.
REQ-021 tmr_start in LOADED -> RUN; tmr_pause in RUN -> LOADED with tmr_remaining held; if both arrive together, pause wins.
REQ-022 tmr_start is ignored in IDLE, RUN and DONE.
REQ-023 tick_tmr = tick_tod AND (tmr_state == RUN); each tick_tmr decrements tmr_remaining by 1.
REQ-024 The decrement that reaches 0 SHALL enter DONE on the same edge, and tmr_expired SHALL be high for exactly that following cycle; the counter never underflows.

Reset
REQ-025 On reset low: all counters 0, stopwatch IDLE, tmr_state IDLE, tmr_remaining 0, and every output 0, immediately and without clk.
REQ-026 The first tick_tod SHALL occur DIV cycles after the first clk edge following reset release.

Configuration
REQ-027 Macro TICK_TENTHS_EN: when defined, a 1-bit output tick_10hz pulses every DIV/10 cycles, the stopwatch phase counter wraps at DIV/10-1, and tick_sw runs at 10*TICK_HZ; CLK_HZ SHALL be divisible by 10*TICK_HZ.
REQ-028 When TICK_TENTHS_EN is undefined, tick_10hz is absent and the REQ-017/018 behaviour applies unchanged.

Structure
REQ-029 Shared package tick_pkg SHALL hold the stopwatch state type (IDLE/RUN/HOLD), the timer state type (REQ-011 encoding) and TMR_W = 12.
REQ-030 Sub-module tick_prescaler (parameter DIV; inputs clr, en; output tick) SHALL be instantiated once for TOD and once for the stopwatch.

Verification (CLK_HZ=20, TICK_HZ=1, DIV=20)
REQ-031 Release reset -> tick_tod at edges 20, 40, 60; no other pulses.
REQ-032 sw_start at edge 5 -> tick_sw at 25; sw_stop at 35, sw_start at 45 -> next tick_sw at 55.
REQ-033 tmr_load with 3, then tmr_start -> tmr_remaining 2, 1, 0 on three tick_tod; tmr_expired for one cycle; tmr_state=3; a later tmr_start is ignored.
REQ-034 In RUN, tmr_load 9 is ignored; tmr_pause -> LOADED with value held; tmr_load 0 in LOADED is ignored.
REQ-035 sw_clear with sw_start in the same cycle while in RUN -> IDLE and sw_running=0.
REQ-036 Reset asserted mid-countdown with remaining=2 -> all outputs 0 at once; no tmr_expired after release.
